bcd_count_ctrl: RTL

Sequencing controller for the two-digit BCD decade counter. It generates the count-enable tick from a prescaler and runs a start/stop/clear state machine. It also advances ones and tens digits with carry and wrap at a programmable BCD target. It sits between the board push-button/debounce logic and the seven-segment display driver, replacing the free-running divided clock with a single-clock, enable-based scheme.

---
 rtl/bcd_count_pkg.sv | 18 +
 rtl/bcd_digit.sv | 37 +++
 rtl/bcd_count_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bcd_count_pkg.sv
// Shared types and constants for the two-digit BCD counter controller.
package bcd_count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade digit: increments on enable, wraps 9 -> 0, synchronous clear.
module bcd_digit
    import bcd_count_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    output bcd_digit_t q_o,
    output logic       co_o
);

    bcd_digit_t q_q;
    bcd_digit_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = bcd_inc(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Carry only when this digit is actually stepping out of 9.
    assign co_o = en_i && (q_q == BCD_MAX);
    assign q_o  = q_q;

endmodule

// File: rtl/bcd_count_ctrl.sv
// Start/stop/clear controller with prescaled count tick for a two-digit BCD counter.
// Optional lap-hold display feature enabled by defining BCD_COUNT_CTRL_LAP_EN.
module bcd_count_ctrl
    import bcd_count_pkg::*;
#(
    parameter int unsigned DIV        = 1000,
    parameter logic [7:0]  TARGET_BCD = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef BCD_COUNT_CTRL_LAP_EN
    input  logic       lap,
`endif
    output logic [7:0] dout,
    output logic       tick_o,
    output logic       wrap,
    output logic       running
);

    localparam int unsigned     PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, wrap_q, running_q;
    logic          step;
    logic          at_target;
    logic          digit_clr;
    logic          ones_co;
    logic          tens_co_unused;
    bcd_digit_t    ones, tens;
    logic [7:0]    count;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        step    = 1'b0;

        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop)  state_d = PAUSE;
            PAUSE:   if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end

        // A stop on the due edge suppresses the step and freezes the phase.
        if (clear) begin
            presc_d = '0;
        end else if (state_q == RUN && !stop) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= step;
            wrap_q    <= step && at_target;
            running_q <= (state_d == RUN);
        end
    end

    assign count     = {tens, ones};
    assign at_target = (count == TARGET_BCD);
    assign digit_clr = clear || (step && at_target);

    bcd_digit u_ones (
        .clk   (clk),
        .rst   (rst),
        .en_i  (step),
        .clr_i (digit_clr),
        .q_o   (ones),
        .co_o  (ones_co)
    );

    bcd_digit u_tens (
        .clk   (clk),
        .rst   (rst),
        .en_i  (ones_co),
        .clr_i (digit_clr),
        .q_o   (tens),
        .co_o  (tens_co_unused)
    );

`ifdef BCD_COUNT_CTRL_LAP_EN
    logic       hold_q;
    logic [7:0] hold_val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= 1'b0;
            hold_val_q <= 8'h00;
        end else if (clear || stop) begin
            hold_q <= 1'b0;
        end else if (lap) begin
            if (hold_q) begin
                hold_q <= 1'b0;
            end else if (state_q == RUN) begin
                hold_q     <= 1'b1;
                hold_val_q <= count;
            end
        end
    end

    assign dout = hold_q ? hold_val_q : count;
`else
    assign dout = count;
`endif

    assign tick_o  = tick_q;
    assign wrap    = wrap_q;
    assign running = running_q;

endmodule
